// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Types and default constants shared by the CPU run/step sequencer.
//   state_t : sequencer states (HALT, STEP, HOLD, RUN)
//   rate_t  : run-rate select code
//   DEF_*   : board defaults for a 50 MHz clock
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        STEP = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_t;

    typedef logic [1:0] rate_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;  // 10 ms
    localparam int DEF_DIV0            = 5000000; // 10 Hz
    localparam int DEF_DIV1            = 500000;  // 100 Hz
    localparam int DEF_DIV2            = 50000;   // 1 kHz
    localparam int DEF_DIV3            = 1;       // full speed
    localparam int DEF_CNT_W           = 23;

endpackage

// File: rtl/step_debounce.sv
// step_debounce
// Synchronises the raw step switch, debounces it and produces a one-cycle
// press pulse on each accepted 0->1 change.
// Ports:
//   clk    : board clock
//   reset  : synchronous, active-high
//   raw    : bouncing switch level, asynchronous to clk
//   level  : debounced switch level
//   press  : 1-cycle pulse, one cycle after level rises
module step_debounce
    import cpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic             level_q;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            level_q    <= 1'b0;
            press      <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            press   <= level & ~level_q;

            // Counts consecutive samples that disagree with the accepted
            // level; a single agreeing sample restarts the count.
            if (sync2 != level) begin
                if (stable_cnt == TERM) begin
                    level      <= sync2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + ONE;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Run/step sequencer producing a single-cycle CPU clock-enable from the
// board clock. Free-runs at a selectable rate, single-steps from a
// debounced switch, and stops on a CPU halt request.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   HALT  | idle; waits for run switch or a step press
//   STEP  | issues exactly one cpuEn pulse
//   HOLD  | waits for the step switch to be released
//   RUN   | free-run, one cpuEn every DIVsel cycles
//
// Ports:
//   clk       : board clock
//   reset     : synchronous, active-high
//   runSw     : raw run switch (1 = run)
//   stepBtn   : raw, bouncing step switch
//   rateSel   : run-rate select (DIV0..DIV3)
//   haltReq   : CPU halt request, clk domain
//   cpuEn     : registered CPU clock-enable pulse
//   running   : 1 while in RUN
//   halted    : sticky CPU-halt flag, cleared by lowering runSw
//   stepCount : count of cpuEn pulses, wraps at 256
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DIV0            = DEF_DIV0,
    parameter int DIV1            = DEF_DIV1,
    parameter int DIV2            = DEF_DIV2,
    parameter int DIV3            = DEF_DIV3,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       runSw,
    input  logic       stepBtn,
    input  logic [1:0] rateSel,
    input  logic       haltReq,
    output logic       cpuEn,
    output logic       running,
    output logic       halted,
    output logic [7:0] stepCount
);

    localparam logic [CNT_W-1:0] DIV0_M1 = CNT_W'(DIV0 - 1);
    localparam logic [CNT_W-1:0] DIV1_M1 = CNT_W'(DIV1 - 1);
    localparam logic [CNT_W-1:0] DIV2_M1 = CNT_W'(DIV2 - 1);
    localparam logic [CNT_W-1:0] DIV3_M1 = CNT_W'(DIV3 - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state;
    rate_t            rate;
    logic             run_s1;
    logic             run_sync;
    logic             step_level;
    logic             step_press;
    logic [CNT_W-1:0] divider;
    logic [CNT_W-1:0] div_term;

    step_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_step_debounce (
        .clk   (clk),
        .reset (reset),
        .raw   (stepBtn),
        .level (step_level),
        .press (step_press)
    );

    assign rate = rate_t'(rateSel);

    always_comb begin
        div_term = DIV0_M1;
        case (rate)
            2'd0:    div_term = DIV0_M1;
            2'd1:    div_term = DIV1_M1;
            2'd2:    div_term = DIV2_M1;
            default: div_term = DIV3_M1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HALT;
            run_s1    <= 1'b0;
            run_sync  <= 1'b0;
            divider   <= '0;
            cpuEn     <= 1'b0;
            running   <= 1'b0;
            halted    <= 1'b0;
            stepCount <= 8'd0;
        end else begin
            run_s1   <= runSw;
            run_sync <= run_s1;
            cpuEn    <= 1'b0;

            // A halt request in RUN below overrides this clear, so a request
            // coinciding with the run switch dropping still flags the halt.
            if (!run_sync) begin
                halted <= 1'b0;
            end

            case (state)
                HALT: begin
                    if (run_sync && !halted) begin
                        state   <= RUN;
                        running <= 1'b1;
                        divider <= '0;
                    end else if (step_press) begin
                        state     <= STEP;
                        cpuEn     <= 1'b1;
                        stepCount <= stepCount + 8'd1;
                    end
                end

                STEP: begin
                    state <= HOLD;
                end

                HOLD: begin
                    if (!step_level) begin
                        state <= HALT;
                    end
                end

                RUN: begin
                    // Exit is checked before pulse generation, so no pulse
                    // leaks out in the exit cycle.
                    if (haltReq || !run_sync) begin
                        state   <= HALT;
                        running <= 1'b0;
                        if (haltReq) begin
                            halted <= 1'b1;
                        end
                    end else if (divider >= div_term) begin
                        // >= lets a switch to a faster rate fire immediately.
                        cpuEn     <= 1'b1;
                        divider   <= '0;
                        stepCount <= stepCount + 8'd1;
                    end else begin
                        divider <= divider + ONE;
                    end
                end

                default: begin
                    state   <= HALT;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule
